store_trace_capture: RTL

- Sits downstream of the pipelined core's MEM stage; consumes the memory-stage store strobe, address and write data.
- Captures every word store landing in a configurable data-memory window (default 0x200..0x227, the ten-word sort array) into a FIFO.
- Streams captured stores out over a valid/ready port for a host/debug sink; counts stores and drops.
- Flags "quiescent" once the program stops writing the window, replacing fixed-length run waits.

---
 rtl/store_trace_capture_pkg.sv | 21 ++
 rtl/store_trace_capture_if.sv | 26 ++
 rtl/store_trace_capture_fifo.sv | 69 ++++++
 rtl/store_trace_capture.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/store_trace_capture_pkg.sv
// Shared types for the store trace capture block.
//   trace_entry_t : one captured store {cycle stamp, word index, data}
//   trace_state_e : quiescence FSM states
//   DEFAULT_BASE  : default first byte address of the watched window
package trace_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_0200;

  typedef struct packed {
    logic [31:0] cycle;
    logic [7:0]  index;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_QUIET  = 2'd2
  } trace_state_e;

endpackage

// File: rtl/store_trace_capture_if.sv
// Trace output stream of the store trace capture block.
//   trace_valid : head entry available
//   trace_ready : sink accepts head entry
//   trace_cycle : cycle stamp of head entry
//   trace_index : word index of head entry within the window
//   trace_data  : stored word of head entry
// Handshake: an entry transfers on every clock edge where trace_valid and
// trace_ready are both high. While trace_valid is high and trace_ready is
// low, the head fields hold steady; trace_valid never depends on trace_ready.
interface store_trace_capture_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_cycle;
  logic [7:0]  trace_index;
  logic [31:0] trace_data;

  modport master (
    output trace_valid, trace_cycle, trace_index, trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_index, trace_data,
    output trace_ready
  );
endinterface

// File: rtl/store_trace_capture_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush (pointers to zero)
//   push     : write wdata; ignored when full unless a pop happens too
//   pop      : drop the head entry; ignored when empty
//   rdata    : head entry (valid while !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // When full, a concurrent pop frees the slot the push writes into.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read out until a push has written it.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_trace_capture.sv
// store_trace_capture: watches MEM-stage stores, captures word stores that
// land in a data-memory window into a FIFO and streams them out, with store
// and drop counters and a quiescence flag.
//   clk, rst    : core clock, asynchronous active-high reset
//   mem_write   : MEM-stage store enable
//   mem_addr    : MEM-stage byte address
//   mem_wdata   : MEM-stage store data
//   enable      : capture enable (0 ignores all stores)
//   clear       : synchronous flush of FIFO, counters, stamp and FSM
//   trace       : trace output stream (master side)
//   store_count : accepted captures, saturating
//   drop_count  : captures lost to full FIFO or misalignment, saturating
//   quiet       : high in QUIET state
//   state_dbg   : current FSM state (0 WAIT, 1 ACTIVE, 2 QUIET)
module store_trace_capture
  import trace_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE,
  parameter int          WINDOW_BYTES = 40,
  parameter int          DEPTH        = 8,
  parameter int          QUIET_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic                  enable,
  input  logic                  clear,
  store_trace_capture_if.master trace,
  output logic [15:0]           store_count,
  output logic [15:0]           drop_count,
  output logic                  quiet,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0]  S_WAIT   = ST_WAIT;
  localparam logic [1:0]  S_ACTIVE = ST_ACTIVE;
  localparam logic [1:0]  S_QUIET  = ST_QUIET;
  localparam logic [15:0] QLAST    = 16'(QUIET_CYCLES - 1);

  logic [31:0]  stamp_q, stamp_d;
  logic [15:0]  store_q, store_d;
  logic [15:0]  drop_q, drop_d;
  logic [1:0]   state_q, state_d;
  logic [15:0]  qcnt_q, qcnt_d;
  logic         quiet_q, quiet_d;

  logic [31:0]  offset;
  logic         in_win, hit, hit_al, hit_mis;
  logic         fifo_full, fifo_empty;
  logic         pop, push, drop_ev;
  trace_entry_t wr_entry, head;

  // Offset form of the window test avoids overflow of BASE_ADDR+WINDOW_BYTES.
  assign offset  = mem_addr - BASE_ADDR;
  assign in_win  = (mem_addr >= BASE_ADDR) && (offset < 32'(WINDOW_BYTES));
  assign hit     = mem_write && enable && in_win;
  assign hit_al  = hit && (mem_addr[1:0] == 2'b00);
  assign hit_mis = hit && (mem_addr[1:0] != 2'b00);

  assign pop     = !fifo_empty && trace.trace_ready;
  assign push    = hit_al && !clear && (!fifo_full || pop);
  assign drop_ev = hit_mis || (hit_al && fifo_full && !pop);

  assign wr_entry = '{cycle: stamp_q, index: offset[9:2], data: mem_wdata};

  sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields read as zero while empty so the port is defined after reset.
  assign trace.trace_valid = !fifo_empty;
  assign trace.trace_cycle = fifo_empty ? '0 : head.cycle;
  assign trace.trace_index = fifo_empty ? '0 : head.index;
  assign trace.trace_data  = fifo_empty ? '0 : head.data;

  always_comb begin
    stamp_d = stamp_q + 32'd1;
    store_d = store_q;
    drop_d  = drop_q;
    state_d = state_q;
    qcnt_d  = qcnt_q;

    if (push && store_q != 16'hFFFF) store_d = store_q + 16'd1;
    if (drop_ev && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    case (state_q)
      S_WAIT: begin
        if (hit_al) begin
          state_d = S_ACTIVE;
          qcnt_d  = '0;
        end
      end
      S_ACTIVE: begin
        // Misaligned stores still show the program is writing the window.
        if (hit) qcnt_d = '0;
        else if (qcnt_q == QLAST) state_d = S_QUIET;
        else qcnt_d = qcnt_q + 16'd1;
      end
      S_QUIET: begin
        if (hit_al) begin
          state_d = S_ACTIVE;
          qcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_WAIT;
        qcnt_d  = '0;
      end
    endcase

    if (clear) begin
      stamp_d = '0;
      store_d = '0;
      drop_d  = '0;
      state_d = S_WAIT;
      qcnt_d  = '0;
    end

    quiet_d = (state_d == S_QUIET);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q <= '0;
      store_q <= '0;
      drop_q  <= '0;
      state_q <= S_WAIT;
      qcnt_q  <= '0;
      quiet_q <= 1'b0;
    end else begin
      stamp_q <= stamp_d;
      store_q <= store_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      quiet_q <= quiet_d;
    end
  end

  assign store_count = store_q;
  assign drop_count  = drop_q;
  assign quiet       = quiet_q;
  assign state_dbg   = state_q;

endmodule
